// File: rtl/img_mem_loader.sv
// Write side of the image block RAM: streams an IMG_W x IMG_W pixel image in
// raster order and stores it row-major inside a zero border PAD cells wide.
module img_mem_loader #(
  parameter int IMG_W  = 64,
  parameter int PAD    = 2,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_din,
  output logic              busy,
  output logic              img_ready,
  output logic [7:0]        frame_cnt
);

  localparam int PW = IMG_W + 2 * PAD;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PW - 1);
  localparam logic [ADDR_W-1:0] LO_IDX   = ADDR_W'(PAD);
  localparam logic [ADDR_W-1:0] HI_IDX   = ADDR_W'(PAD + IMG_W);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] addr;
  logic              interior;
  logic              advance;

  assign interior = (row >= LO_IDX) && (row < HI_IDX) && (col >= LO_IDX) && (col < HI_IDX);
  assign s_ready  = (state == FILL) && interior;
  assign advance  = (state == FILL) && (!interior || s_valid);

  // addr tracks row*PW+col incrementally: the scan is strictly row-major,
  // so every advance moves exactly one address forward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      addr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      busy      <= 1'b0;
      img_ready <= 1'b0;
      frame_cnt <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FILL;
            row       <= '0;
            col       <= '0;
            addr      <= '0;
            img_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        FILL: begin
          if (advance) begin
            mem_we   <= 1'b1;
            mem_addr <= addr;
            mem_din  <= interior ? s_data : '0;
            addr     <= addr + 1'b1;
            if (col == LAST_IDX) begin
              col <= '0;
              if (row == LAST_IDX) state <= DONE;
              else                 row   <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          img_ready <= 1'b1;
          frame_cnt <= frame_cnt + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_mem_loader.sv
// Directed bench for img_mem_loader: a default 64x64/PAD=2 instance, a 4x4/PAD=1
// instance and a 4x4/PAD=0 instance, each with a write/accept monitor feeding a RAM model.
module tb_img_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // default instance (b*), padded small instance (p*), unpadded small instance (n*)
  logic        bStart = 0, bValid = 0, bReady, bWe, bBusy, bImg;
  logic [12:0] bAddr;
  logic [7:0]  bDin, bCnt, bData;
  logic        pStart = 0, pValid = 0, pReady, pWe, pBusy, pImg;
  logic [12:0] pAddr;
  logic [7:0]  pDin, pCnt, pData;
  logic        nStart = 0, nValid = 0, nReady, nWe, nBusy, nImg;
  logic [12:0] nAddr;
  logic [7:0]  nDin, nCnt, nData;

  img_mem_loader uBig (
    .clk(clk), .rst(rst), .start(bStart), .s_valid(bValid), .s_data(bData),
    .s_ready(bReady), .mem_we(bWe), .mem_addr(bAddr), .mem_din(bDin),
    .busy(bBusy), .img_ready(bImg), .frame_cnt(bCnt));

  img_mem_loader #(.IMG_W(4), .PAD(1)) uPad (
    .clk(clk), .rst(rst), .start(pStart), .s_valid(pValid), .s_data(pData),
    .s_ready(pReady), .mem_we(pWe), .mem_addr(pAddr), .mem_din(pDin),
    .busy(pBusy), .img_ready(pImg), .frame_cnt(pCnt));

  img_mem_loader #(.IMG_W(4), .PAD(0)) uNoPad (
    .clk(clk), .rst(rst), .start(nStart), .s_valid(nValid), .s_data(nData),
    .s_ready(nReady), .mem_we(nWe), .mem_addr(nAddr), .mem_din(nDin),
    .busy(nBusy), .img_ready(nImg), .frame_cnt(nCnt));

  int checkCount = 0;
  int passCount  = 0;
  int cycleNo    = 0;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Monitors: log every write into a RAM model (checking address order) and
  // count accepts; the source data is simply the number of pixels accepted so far.
  logic bClr = 0, pClr = 0, nClr = 0;
  logic bTake = 0, pTake = 0, nTake = 0;
  logic bImgPrev = 0;
  int   bWrites = 0, bSeqErr = 0, bRises = 0, bAccepts = 0;
  int   pWrites = 0, pSeqErr = 0, pAccepts = 0;
  int   nWrites = 0, nSeqErr = 0, nAccepts = 0;
  logic [7:0] bRam [0:8191];
  logic [7:0] pRam [0:63];
  logic [7:0] nRam [0:63];

  always @(negedge clk) begin
    if (bClr) begin
      bWrites = 0; bSeqErr = 0; bRises = 0;
      for (int i = 0; i < 8192; i++) bRam[i] = 8'hAA;
    end else begin
      if (bWe) begin
        if (int'(bAddr) != bWrites) bSeqErr++;
        bRam[bAddr] = bDin;
        bWrites++;
      end
      if (bImg && !bImgPrev) bRises++;
    end
    bImgPrev = bImg;
    bTake = bValid && bReady;
  end

  always @(negedge clk) begin
    if (pClr) begin
      pWrites = 0; pSeqErr = 0;
      for (int i = 0; i < 64; i++) pRam[i] = 8'hAA;
    end else if (pWe) begin
      if (int'(pAddr) != pWrites % 36) pSeqErr++;
      if (pAddr < 13'd64) pRam[pAddr[5:0]] = pDin;
      pWrites++;
    end
    pTake = pValid && pReady;
  end

  always @(negedge clk) begin
    if (nClr) begin
      nWrites = 0; nSeqErr = 0;
      for (int i = 0; i < 64; i++) nRam[i] = 8'hAA;
    end else if (nWe) begin
      if (int'(nAddr) != nWrites) nSeqErr++;
      if (nAddr < 13'd64) nRam[nAddr[5:0]] = nDin;
      nWrites++;
    end
    nTake = nValid && nReady;
  end

  always @(posedge clk) begin
    if (bClr) bAccepts <= 0; else if (bTake) bAccepts <= bAccepts + 1;
    if (pClr) pAccepts <= 0; else if (pTake) pAccepts <= pAccepts + 1;
    if (nClr) nAccepts <= 0; else if (nTake) nAccepts <= nAccepts + 1;
  end

  assign bData = 8'(bAccepts);
  assign pData = 8'(pAccepts);
  assign nData = 8'(nAccepts);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // One-cycle start pulse; returns one step after the edge that samples it.
  task automatic applyStimulus(input int which);
    @(posedge clk); #1;
    case (which)
      0: bStart = 1'b1;
      1: pStart = 1'b1;
      default: nStart = 1'b1;
    endcase
    @(posedge clk); #1;
    bStart = 1'b0; pStart = 1'b0; nStart = 1'b0;
  endtask

  task automatic waitImg(input int which, input int budget, output int cyc);
    logic img;
    cyc = 0;
    img = 1'b0;
    while (!img && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      case (which)
        0: img = bImg;
        1: img = pImg;
        default: img = nImg;
      endcase
    end
    checkOutput("img_ready_reached", img, 1);
  endtask

  task automatic waitBigWrites(input int target, input int budget);
    int cyc;
    cyc = 0;
    while (bWrites < target && cyc < budget) begin
      @(negedge clk); #1;
      cyc++;
    end
    checkOutput("big_write_target", bWrites, target);
  endtask

  initial begin
    int cyc, errs, c0, r, c;
    bClr = 1; pClr = 1; nClr = 1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_s_ready", bReady, 0);
    checkOutput("rst_mem_we", bWe, 0);
    checkOutput("rst_mem_addr", bAddr, 0);
    checkOutput("rst_mem_din", bDin, 0);
    checkOutput("rst_busy", bBusy, 0);
    checkOutput("rst_img_ready", bImg, 0);
    checkOutput("rst_frame_cnt", bCnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    bClr = 0; pClr = 0; nClr = 0;

    // PAD=0: every cell interior, address equals pixel index
    nValid = 1'b1;
    applyStimulus(2);
    waitImg(2, 100, cyc);
    checkOutput("nopad_cycles", cyc, 17);
    checkOutput("nopad_writes", nWrites, 16);
    checkOutput("nopad_accepts", nAccepts, 16);
    checkOutput("nopad_addr_order", nSeqErr, 0);
    errs = 0;
    for (int i = 0; i < 16; i++) if (nRam[i] !== 8'(i)) errs++;
    checkOutput("nopad_data", errs, 0);
    checkOutput("nopad_frame_cnt", nCnt, 1);

    // IMG_W=4, PAD=1 with s_valid toggling: border zeros, interior holds on gaps
    pValid = 1'b1;
    applyStimulus(1);
    cyc = 0;
    while (!pImg && cyc < 200) begin
      @(posedge clk); #1;
      pValid = ~pValid;
      cyc++;
    end
    checkOutput("pad_img_ready", pImg, 1);
    checkOutput("pad_writes", pWrites, 36);
    checkOutput("pad_accepts", pAccepts, 16);
    checkOutput("pad_addr_order", pSeqErr, 0);
    errs = 0;
    for (int i = 0; i < 36; i++) begin
      r = i / 6;
      c = i % 6;
      if (r < 1 || r > 4 || c < 1 || c > 4) begin
        if (pRam[i] !== 8'd0) errs++;
      end else if (pRam[i] !== 8'((r - 1) * 4 + (c - 1))) errs++;
    end
    checkOutput("pad_frame_contents", errs, 0);
    checkOutput("pad_addr7", pRam[7], 0);
    checkOutput("pad_addr10", pRam[10], 3);
    checkOutput("pad_addr13", pRam[13], 4);
    checkOutput("pad_addr28", pRam[28], 15);
    checkOutput("pad_addr29", pRam[29], 0);
    checkOutput("pad_no_overrun", pRam[36], 8'hAA);

    // back-to-back frames until frame_cnt wraps
    pValid = 1'b1;
    for (int f = 0; f < 255; f++) begin
      applyStimulus(1);
      waitImg(1, 100, cyc);
      if (f == 253) checkOutput("pad_frame_cnt_255", pCnt, 255);
    end
    checkOutput("pad_last_frame_cycles", cyc, 37);
    checkOutput("pad_frame_cnt_wrap", pCnt, 0);

    // default instance: reset at interior cell r=30,c=40 (addr 2080)
    bValid = 1'b1;
    applyStimulus(0);
    checkOutput("big_busy_after_start", bBusy, 1);
    waitBigWrites(2080, 3000);
    checkOutput("mid_s_ready_interior", bReady, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_mem_we", bWe, 0);
    checkOutput("mid_rst_s_ready", bReady, 0);
    checkOutput("mid_rst_busy", bBusy, 0);
    checkOutput("mid_rst_img_ready", bImg, 0);
    checkOutput("mid_rst_frame_cnt", bCnt, 0);
    bClr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    bClr = 1'b0;

    // full frame with start pulses mid-FILL and in the DONE cycle
    applyStimulus(0);
    c0 = cycleNo;
    @(posedge clk); #1;
    checkOutput("restart_mem_we", bWe, 1);
    checkOutput("restart_mem_addr", bAddr, 0);
    waitBigWrites(1000, 1500);
    bStart = 1'b1;
    @(posedge clk); #1;
    bStart = 1'b0;
    waitBigWrites(4624, 4000);
    checkOutput("done_cycle_img_ready", bImg, 0);
    bStart = 1'b1;
    @(posedge clk); #1;
    bStart = 1'b0;
    checkOutput("frame_img_ready", bImg, 1);
    checkOutput("frame_latency", cycleNo - c0, 4625);
    checkOutput("frame_writes", bWrites, 4624);
    checkOutput("frame_accepts", bAccepts, 4096);
    checkOutput("frame_addr_order", bSeqErr, 0);
    checkOutput("frame_addr0", bRam[0], 0);
    checkOutput("frame_addr137", bRam[137], 0);
    checkOutput("frame_addr138", bRam[138], 0);
    checkOutput("frame_addr139", bRam[139], 1);
    checkOutput("frame_addr206", bRam[206], 64);
    checkOutput("frame_addr4485", bRam[4485], 255);
    checkOutput("frame_addr4623", bRam[4623], 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("after_busy", bBusy, 0);
    checkOutput("after_img_ready", bImg, 1);
    checkOutput("after_rises", bRises, 1);
    checkOutput("after_frame_cnt", bCnt, 1);

    // restart from img_ready with no pixels offered: border rows rewritten, then hold
    bValid = 1'b0;
    bClr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bClr = 1'b0;
    applyStimulus(0);
    checkOutput("rearm_img_ready", bImg, 0);
    checkOutput("rearm_busy", bBusy, 1);
    waitBigWrites(138, 300);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("hold_writes", bWrites, 138);
    checkOutput("hold_accepts", bAccepts, 0);
    checkOutput("hold_s_ready", bReady, 1);
    checkOutput("hold_mem_we", bWe, 0);
    errs = 0;
    for (int i = 0; i < 138; i++) if (bRam[i] !== 8'd0) errs++;
    checkOutput("hold_border_zeros", errs, 0);
    checkOutput("hold_addr138_untouched", bRam[138], 8'hAA);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
